grant_pkt_mux: RTL and testbench

GRANT_PKT_MUX -- requirements
Module: grant_pkt_mux

---
 rtl/grant_pkt_mux.sv | 130 +++++++++++++
 tb/tb_grant_pkt_mux.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/grant_pkt_mux.sv
// Packet-atomic N:1 mux with an external round-robin arbiter. Arbitration only
// happens at packet boundaries, and the winner owns the output until its last beat.
module grant_pkt_mux_lane (
  input  logic i_rst,
  input  logic i_lock,
  input  logic i_own,
  input  logic i_grant,
  input  logic i_valid,
  input  logic i_slot_free,
  input  logic i_bad,
  output logic o_ready
);
  // A malformed grant must never turn into an accepted beat.
  assign o_ready = ~i_rst & i_slot_free &
                   (i_lock ? i_own : (i_grant & i_valid & ~i_bad));
endmodule

module grant_pkt_mux #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         src_valid,
  input  logic [N*W-1:0]       src_data,
  input  logic [N-1:0]         src_last,
  output logic [N-1:0]         src_ready,
  output logic [N-1:0]         arb_req,
  input  logic [N-1:0]         arb_grant,
  output logic                 arb_stall,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  output logic                 out_last,
  output logic [$clog2(N)-1:0] out_src,
  input  logic                 out_ready,
  output logic [15:0]          pkt_cnt,
  output logic                 err
);
  localparam int SW = $clog2(N);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [SW-1:0] r_owner;
  logic          r_out_valid, r_out_last, r_err;
  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_out_src;
  logic [15:0]   r_pkt_cnt;

  logic          w_lock, w_slot_free, w_bad, w_load, w_sel_last;
  logic [SW-1:0] w_gidx, w_sel;
  logic [W-1:0]  w_sel_data;

  assign w_lock      = (r_state == LOCK);
  assign w_slot_free = ~r_out_valid | out_ready;
  assign arb_stall   = rst | w_lock | ~w_slot_free;
  assign arb_req     = w_lock ? '0 : src_valid;

  // More than one grant bit, or a grant to a silent channel, while the arbiter is live.
  assign w_bad = ~w_lock & ~arb_stall &
                 ((|(arb_grant & (arb_grant - 1'b1))) | (|(arb_grant & ~src_valid)));

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < N; i++)
      if (arb_grant[i]) w_gidx = SW'(i);
  end

  assign w_sel      = w_lock ? r_owner : w_gidx;
  assign w_sel_data = src_data[w_sel*W +: W];
  assign w_sel_last = src_last[w_sel];

  for (genvar g = 0; g < N; g++) begin : g_lane
    grant_pkt_mux_lane u_lane (
      .i_rst       (rst),
      .i_lock      (w_lock),
      .i_own       (r_owner == SW'(g)),
      .i_grant     (arb_grant[g]),
      .i_valid     (src_valid[g]),
      .i_slot_free (w_slot_free),
      .i_bad       (w_bad),
      .o_ready     (src_ready[g])
    );
  end

  // At most one ready bit is ever high, so any ready means the selected beat loads.
  assign w_load = |(src_ready & src_valid);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_load && !w_sel_last) w_state_nxt = LOCK;
      LOCK:    if (w_load &&  w_sel_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_src   <= '0;
      r_pkt_cnt   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_last  <= w_sel_last;
        r_out_src   <= w_sel;
        r_owner     <= w_sel;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (r_out_valid && out_ready && r_out_last) r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if (w_bad) r_err <= 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_src   = r_out_src;
  assign pkt_cnt   = r_pkt_cnt;
  assign err       = r_err;
endmodule

// File: tb/tb_grant_pkt_mux.sv
// Directed bench for grant_pkt_mux, ending with a round-robin soak that wraps pkt_cnt.
module tb_grant_pkt_mux;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk, rst;
  logic [N-1:0]   src_valid, src_last, src_ready, arb_req, arb_grant;
  logic [N*W-1:0] src_data;
  logic           arb_stall, out_valid, out_last, out_ready, err;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;
  logic [15:0]    pkt_cnt;

  int total = 0;
  int bad   = 0;

  grant_pkt_mux #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_data(src_data),
    .src_last(src_last), .src_ready(src_ready), .arb_req(arb_req),
    .arb_grant(arb_grant), .arb_stall(arb_stall), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready), .pkt_cnt(pkt_cnt), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic setd(input int ch, input logic [31:0] d);
    src_data[ch*W +: W] = d;
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] exp_d;
    int sent, got, cyc, ptr;

    rst = 1'b1; src_valid = 4'hF; src_last = '0; src_data = '0;
    arb_grant = 4'b0001; out_ready = 1'b1;
    #1;
    chk("rst_src_ready", src_ready, 0);
    chk("rst_stall", arb_stall, 1);
    tick; tick;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_err", err, 0);

    // two single-beat packets from ch0 then ch2, back to back
    rst = 1'b0; src_valid = 4'b0101; src_last = 4'b1111; arb_grant = 4'b0001;
    setd(0, 32'hD000_0000); setd(2, 32'hD000_0002);
    #1;
    chk("a_req", arb_req, 4'b0101);
    chk("a_ready0", src_ready, 4'b0001);
    chk("a_stall", arb_stall, 0);
    tick;
    chk("a_data0", out_data, 32'hD000_0000);
    chk("a_src0", out_src, 0);
    chk("a_valid0", out_valid, 1);
    arb_grant = 4'b0100; #1;
    chk("a_ready2", src_ready, 4'b0100);
    tick;
    chk("a_data2", out_data, 32'hD000_0002);
    chk("a_src2", out_src, 2);
    src_valid = '0; arb_grant = '0;
    tick;
    chk("a_valid_drop", out_valid, 0);
    chk("a_pkt_cnt", pkt_cnt, 2);

    // 3-beat packet on ch1 while ch3 waits
    src_valid = 4'b1010; src_last = 4'b0000; arb_grant = 4'b0010;
    setd(1, 32'hB000_0001); setd(3, 32'hC000_0003);
    #1;
    chk("b_ready1", src_ready, 4'b0010);
    tick;
    chk("b_src1", out_src, 1);
    chk("b_data1", out_data, 32'hB000_0001);
    setd(1, 32'hB000_0002); arb_grant = 4'b1000; #1;
    chk("b_stall2", arb_stall, 1);
    chk("b_req_lock", arb_req, 0);
    chk("b_ready_lock2", src_ready, 4'b0010);
    tick;
    chk("b_data2", out_data, 32'hB000_0002);
    chk("b_src2", out_src, 1);
    setd(1, 32'hB000_0003); src_last = 4'b0010; arb_grant = '0; #1;
    chk("b_stall3", arb_stall, 1);
    chk("b_ready_lock3", src_ready, 4'b0010);
    tick;
    chk("b_data3", out_data, 32'hB000_0003);
    chk("b_last3", out_last, 1);
    chk("b_src3", out_src, 1);
    chk("b_stall_free", arb_stall, 0);
    src_valid = 4'b1000; src_last = 4'b1000; arb_grant = 4'b1000; #1;
    chk("b_ready3", src_ready, 4'b1000);
    tick;
    chk("b_ch3_src", out_src, 3);
    chk("b_ch3_data", out_data, 32'hC000_0003);
    chk("b_pkt_cnt", pkt_cnt, 3);

    // downstream backpressure for 4 cycles
    out_ready = 1'b0; src_valid = 4'b0001; src_last = 4'b0001; arb_grant = '0;
    setd(0, 32'hE000_0000);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("c_stall", arb_stall, 1);
      chk("c_ready", src_ready, 0);
      tick;
      chk("c_hold_data", out_data, 32'hC000_0003);
      chk("c_hold_src", out_src, 3);
      chk("c_hold_last", out_last, 1);
      chk("c_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1; arb_grant = 4'b0001; #1;
    chk("c_release_ready", src_ready, 4'b0001);
    tick;
    chk("c_next_data", out_data, 32'hE000_0000);
    chk("c_next_src", out_src, 0);
    chk("c_pkt_cnt", pkt_cnt, 4);
    src_valid = '0; arb_grant = '0;
    tick;
    chk("c_drain_valid", out_valid, 0);
    chk("c_drain_cnt", pkt_cnt, 5);

    // two-hot grant is an error and moves nothing
    src_valid = 4'b0011; src_last = 4'b1111; arb_grant = 4'b0011; #1;
    chk("d_ready_bad", src_ready, 0);
    tick;
    chk("d_err", err, 1);
    chk("d_no_load", out_valid, 0);
    src_valid = '0; arb_grant = '0;
    tick;
    chk("d_err_sticky", err, 1);
    chk("d_cnt_hold", pkt_cnt, 5);

    // reset in the middle of a 4-beat packet on ch2
    src_valid = 4'b0100; src_last = '0; arb_grant = 4'b0100; setd(2, 32'hF000_0001);
    tick;
    chk("e_beat1", out_data, 32'hF000_0001);
    arb_grant = '0; setd(2, 32'hF000_0002);
    tick;
    chk("e_beat2", out_data, 32'hF000_0002);
    rst = 1'b1; #1;
    chk("e_rst_ready", src_ready, 0);
    chk("e_rst_stall", arb_stall, 1);
    tick;
    rst = 1'b0; #1;
    chk("e_valid", out_valid, 0);
    chk("e_pkt_cnt", pkt_cnt, 0);
    chk("e_err_clr", err, 0);
    chk("e_idle_stall", arb_stall, 0);
    chk("e_idle_req", arb_req, 4'b0100);

    // soak: 65536 single-beat packets, random backpressure, pkt_cnt must wrap to 0
    src_valid = '0; src_last = 4'hF; arb_grant = '0;
    tick;
    sent = 0; got = 0; cyc = 0; ptr = N - 1;
    while (got < 65536 && cyc < 90000) begin
      src_valid = (sent < 65536) ? 4'hF : 4'h0;
      for (int i = 0; i < N; i++) setd(i, (32'(i) << 28) | 32'(sent));
      out_ready = ($urandom_range(15) != 0);
      #1;
      arb_grant = '0;
      if (!arb_stall)
        for (int k = 1; k <= N; k++)
          if (arb_grant == '0 && arb_req[(ptr + k) % N]) arb_grant[(ptr + k) % N] = 1'b1;
      #1;
      for (int i = 0; i < N; i++)
        if (src_ready[i] && src_valid[i]) begin
          q.push_back(src_data[i*W +: W]);
          sent++;
          ptr = i;
        end
      if (out_valid && out_ready) begin
        exp_d = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
        chk("f_beat", out_data, exp_d);
        got++;
      end
      tick;
      cyc++;
    end
    chk("f_got", got, 65536);
    chk("f_sent", sent, 65536);
    chk("f_queue_empty", q.size(), 0);
    chk("f_pkt_wrap", pkt_cnt, 0);
    chk("f_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
